sipo_4bit_deser: RTL

//  Serial-in/parallel-out deserializer sitting directly upstream of the 4-bit PIPO register.

---
 rtl/sipo_pkg.sv | 20 ++
 rtl/sipo_bit_counter.sv | 35 +++
 rtl/sipo_4bit_deser.sv | 83 ++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared constants and helpers for serial shift-register blocks
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 32;

  // Counter width for 0..n-1, never narrower than one bit
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit width_ok(input int w);
    return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// rtl/sipo_bit_counter.sv - mod-WIDTH bit position counter with sync restart-to-1
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          restart,
  output logic [CW-1:0] count,
  output logic          last_bit
);

  logic [CW-1:0] count_q, count_d;

  assign last_bit = en && !restart && (count_q == CW'(WIDTH - 1));
  assign count    = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      if (restart)       count_d = CW'(1);
      else if (last_bit) count_d = '0;
      else               count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/sipo_4bit_deser.sv
// rtl/sipo_4bit_deser.sv - serial-in/parallel-out deserializer feeding a PIPO register
module sipo_4bit_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             word_valid,
  output logic [CW-1:0]    bit_cnt
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("sipo_4bit_deser: WIDTH out of range");
  end

  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] word_bar_q, word_bar_d;
  logic             word_valid_q, word_valid_d;
  logic [WIDTH-1:0] shifted, start_word;
  logic             last_bit;

  sipo_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (sin_valid),
    .restart  (sync),
    .count    (bit_cnt),
    .last_bit (last_bit)
  );

  always_comb begin
    shifted    = '0;
    start_word = '0;
    if (MSB_FIRST) begin
      shifted    = {sreg_q[WIDTH-2:0], sin};
      start_word = {{(WIDTH-1){1'b0}}, sin};
    end else begin
      shifted    = {sin, sreg_q[WIDTH-1:1]};
      start_word = {sin, {(WIDTH-1){1'b0}}};
    end
  end

  // A sync bit seeds a fresh word; the completed word is the shift including this bit
  always_comb begin
    sreg_d       = sreg_q;
    word_d       = word_q;
    word_bar_d   = word_bar_q;
    word_valid_d = last_bit;
    if (sin_valid) sreg_d = sync ? start_word : shifted;
    if (last_bit) begin
      word_d     = shifted;
      word_bar_d = ~shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q       <= '0;
      word_q       <= '0;
      word_bar_q   <= '1;
      word_valid_q <= 1'b0;
    end else begin
      sreg_q       <= sreg_d;
      word_q       <= word_d;
      word_bar_q   <= word_bar_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign q          = word_q;
  assign q_bar      = word_bar_q;
  assign word_valid = word_valid_q;

endmodule
